// File: rtl/exe_lane_gate_ctrl_pkg.sv
// Shared types and dynamic-config defaults for the execution-lane gate sequencer.
package exe_lane_gate_ctrl_pkg;

  // Lane power/activity sequence states.
  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_QUIESCE = 3'd2,
    ST_OFF     = 3'd3,
    ST_WAKE    = 3'd4
  } lane_gate_state_e;

  // Dynamic-config defaults for the wake and quiesce windows (legal range 1..15).
  localparam int DEFAULT_WAKE_CYCLES    = 2;
  localparam int DEFAULT_QUIESCE_CYCLES = 2;

  // Width of the shared wake/quiesce countdown timer.
  localparam int TIMER_W = 4;

endpackage

// File: rtl/exe_lane_gate_ctrl_inflight_counter.sv
// Saturating up/down count of live ops in the lane pipe, with flush clear
// and single-cycle underflow/overflow indications.
module lane_inflight_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [WIDTH-1:0] cnt,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_next;

  // Next count: flush clears, opposing inc/dec cancel, both ends saturate.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    cnt_next  = cnt;
    underflow = dec && !inc && (cnt == '0);
    overflow  = inc && !dec && (cnt == CNT_MAX);
    if (flush) begin
      cnt_next = '0;
    end else if (inc && !dec && !overflow) begin
      cnt_next = cnt + 1'b1;
    end else if (dec && !inc && !underflow) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/exe_lane_gate_ctrl.sv
// Per-lane drain-then-gate / wake-then-enable sequencer for one memory
// execution pipe. Never gates the clock while an op is still live.
module exe_lane_gate_ctrl
  import exe_lane_gate_ctrl_pkg::*;
#(
  parameter int INFLIGHT_LOG   = 3,
  parameter int WAKE_CYCLES    = DEFAULT_WAKE_CYCLES,
  parameter int QUIESCE_CYCLES = DEFAULT_QUIESCE_CYCLES,
  parameter bit RESET_ACTIVE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    laneEnReq_i,
  input  logic                    issueValid_i,
  input  logic                    completeValid_i,
  input  logic                    flush_i,
  output logic                    laneActive_o,
  output logic                    issueBlock_o,
  output logic                    cfgStable_o,
  output logic [INFLIGHT_LOG-1:0] inflightCnt_o,
  output logic                    protErr_o
);

  localparam lane_gate_state_e       RESET_STATE  = RESET_ACTIVE ? ST_ON : ST_OFF;
  localparam logic [TIMER_W-1:0]     WAKE_LOAD    = TIMER_W'(WAKE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     QUIESCE_LOAD = TIMER_W'(QUIESCE_CYCLES - 1);

  lane_gate_state_e   state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               underflow, overflow;
  logic               active_next, block_next, err_next;

  lane_inflight_counter #(
    .WIDTH(INFLIGHT_LOG)
  ) u_inflight (
    .clk      (clk),
    .rst_n    (reset),
    .inc      (issueValid_i),
    .dec      (completeValid_i),
    .flush    (flush_i),
    .cnt      (inflightCnt_o),
    .underflow(underflow),
    .overflow (overflow)
  );

  // State and countdown timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Sequencing: an enable request always wins; quiesce aborts on any pipe activity.
  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      ST_ON: begin
        if (!laneEnReq_i) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (laneEnReq_i) begin
          state_next = ST_ON;
        end else if ((inflightCnt_o == '0) && !issueValid_i) begin
          state_next = ST_QUIESCE;
          timer_next = QUIESCE_LOAD;
        end
      end
      ST_QUIESCE: begin
        if (laneEnReq_i) begin
          state_next = ST_ON;
        end else if ((inflightCnt_o != '0) || issueValid_i || completeValid_i) begin
          state_next = ST_DRAIN;
        end else if (timer == '0) begin
          state_next = ST_OFF;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      ST_OFF: begin
        if (laneEnReq_i) begin
          state_next = ST_WAKE;
          timer_next = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (!laneEnReq_i) begin
          state_next = ST_OFF;
        end else if (timer == '0) begin
          state_next = ST_ON;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Output decode from the upcoming state, plus sticky protocol-error detection.
  always_comb begin
    active_next = (state_next != ST_OFF);
    block_next  = (state_next != ST_ON);
    err_next    = protErr_o | underflow | overflow |
                  (issueValid_i & issueBlock_o) |
                  (completeValid_i & ~laneActive_o);
    cfgStable_o = (laneEnReq_i & (state == ST_ON)) | (~laneEnReq_i & (state == ST_OFF));
  end

  // Registered lane controls and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      laneActive_o <= RESET_ACTIVE;
      issueBlock_o <= !RESET_ACTIVE;
      protErr_o    <= 1'b0;
    end else begin
      laneActive_o <= active_next;
      issueBlock_o <= block_next;
      protErr_o    <= err_next;
    end
  end

endmodule

// File: tb/tb_exe_lane_gate_ctrl.sv
// Self-checking bench for exe_lane_gate_ctrl: directed sequences with literal
// expectations, then randomized traffic against a behavioural model.
module tb_exe_lane_gate_ctrl;

  localparam int LOG  = 3;
  localparam int WAKE = 2;
  localparam int QUI  = 2;
  localparam int MAXC = 7;

  // Model lane phases.
  localparam int P_ON = 0, P_DRAIN = 1, P_QUI = 2, P_OFF = 3, P_WAKE = 4;

  logic           clk = 1'b0;
  logic           reset, en, iss, cmp, fl;
  logic           act, blk, stab, err;
  logic [LOG-1:0] cnt;

  exe_lane_gate_ctrl #(
    .INFLIGHT_LOG  (LOG),
    .WAKE_CYCLES   (WAKE),
    .QUIESCE_CYCLES(QUI),
    .RESET_ACTIVE  (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .laneEnReq_i    (en),
    .issueValid_i   (iss),
    .completeValid_i(cmp),
    .flush_i        (fl),
    .laneActive_o   (act),
    .issueBlock_o   (blk),
    .cfgStable_o    (stab),
    .inflightCnt_o  (cnt),
    .protErr_o      (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  int m_phase, m_left, m_cnt;
  bit m_act, m_blk, m_err;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_ON;
    m_left  = 0;
    m_cnt   = 0;
    m_act   = 1'b1;
    m_blk   = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock of the lane rules, using the inputs present at the edge.
  task automatic model_step();
    int nxt;
    if (!reset) begin
      model_reset();
      return;
    end
    if ((cmp && !iss && m_cnt == 0) || (iss && !cmp && m_cnt == MAXC) ||
        (iss && m_blk) || (cmp && !m_act))
      m_err = 1'b1;
    case (m_phase)
      P_ON:    if (!en) m_phase = P_DRAIN;
      P_DRAIN: begin
        if (en) m_phase = P_ON;
        else if (m_cnt == 0 && !iss) begin m_phase = P_QUI; m_left = QUI - 1; end
      end
      P_QUI: begin
        if (en) m_phase = P_ON;
        else if (m_cnt != 0 || iss || cmp) m_phase = P_DRAIN;
        else if (m_left == 0) m_phase = P_OFF;
        else m_left--;
      end
      P_OFF:   if (en) begin m_phase = P_WAKE; m_left = WAKE - 1; end
      default: begin
        if (!en) m_phase = P_OFF;
        else if (m_left == 0) m_phase = P_ON;
        else m_left--;
      end
    endcase
    if (fl) m_cnt = 0;
    else begin
      nxt   = m_cnt + int'(iss) - int'(cmp);
      m_cnt = (nxt < 0) ? 0 : (nxt > MAXC) ? MAXC : nxt;
    end
    m_act = (m_phase != P_OFF);
    m_blk = (m_phase != P_ON);
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_on) begin
      check("laneActive", 8'(act), 8'(m_act));
      check("issueBlock", 8'(blk), 8'(m_blk));
      check("inflightCnt", 8'(cnt), 8'(m_cnt));
      check("protErr", 8'(err), 8'(m_err));
      check("cfgStable", 8'(stab),
            8'((m_phase == P_ON && en) || (m_phase == P_OFF && !en)));
    end
  end

  // Apply inputs, then advance one clock; returns 2 time units after the edge.
  task automatic cycle(input bit e, input bit i, input bit c, input bit f);
    en  = e;
    iss = i;
    cmp = c;
    fl  = f;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_protErr", 8'(err), 8'd0);
    check("rst_laneActive", 8'(act), 8'd1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    bit e, i, c, f;
    reset = 1'b0;
    en = 1'b1; iss = 1'b0; cmp = 1'b0; fl = 1'b0;
    model_reset();
    check_on = 1'b1;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("reset_active", 8'(act), 8'd1);
    check("reset_block", 8'(blk), 8'd0);
    check("reset_cnt", 8'(cnt), 8'd0);
    check("reset_stable", 8'(stab), 8'd1);
    reset = 1'b1;
    cycle(1, 0, 0, 0);

    // Gate-off from an empty pipe.
    cycle(0, 0, 0, 0);
    check("off_c1_block", 8'(blk), 8'd1);
    check("off_c1_active", 8'(act), 8'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("off_c3_active", 8'(act), 8'd1);
    cycle(0, 0, 0, 0);
    check("off_c4_active", 8'(act), 8'd0);
    check("off_c4_stable", 8'(stab), 8'd1);

    // Wake and unblock.
    cycle(1, 0, 0, 0);
    check("wake_c1_active", 8'(act), 8'd1);
    check("wake_c1_block", 8'(blk), 8'd1);
    cycle(1, 0, 0, 0);
    check("wake_c2_block", 8'(blk), 8'd1);
    cycle(1, 0, 0, 0);
    check("wake_c3_block", 8'(blk), 8'd0);
    check("wake_c3_stable", 8'(stab), 8'd1);

    // Drain three live ops, one completion every two cycles.
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
    check("drain_cnt3", 8'(cnt), 8'd3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("drain_hold_active", 8'(act), 8'd1);
    cycle(0, 0, 1, 0);
    check("drain_last_cnt", 8'(cnt), 8'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("drain_q_active", 8'(act), 8'd1);
    cycle(0, 0, 0, 0);
    check("drain_gate_active", 8'(act), 8'd0);
    check("drain_err", 8'(err), 8'd0);

    // Flush while draining.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("flush_cnt", 8'(cnt), 8'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("flush_gate_active", 8'(act), 8'd0);
    check("flush_err", 8'(err), 8'd0);

    // Request dropped during wake.
    cycle(1, 0, 0, 0);
    check("wabort_c1_active", 8'(act), 8'd1);
    cycle(0, 0, 0, 0);
    check("wabort_active", 8'(act), 8'd0);
    check("wabort_stable", 8'(stab), 8'd1);

    // Re-request during quiesce returns to ON without gating.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("requi_q_active", 8'(act), 8'd1);
    cycle(1, 0, 0, 0);
    check("requi_active", 8'(act), 8'd1);
    check("requi_block", 8'(blk), 8'd0);

    // Issue while blocked sets the sticky error.
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("perr_blocked_issue", 8'(err), 8'd1);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 0);
    check("perr_sticky", 8'(err), 8'd1);
    do_reset();

    // Completion at zero count: error and no wrap.
    cycle(1, 0, 1, 0);
    check("perr_underflow", 8'(err), 8'd1);
    check("underflow_cnt", 8'(cnt), 8'd0);
    do_reset();

    // Randomized traffic with occasional mid-sequence resets.
    for (int n = 0; n < 4000; n++) begin
      if (reset && $urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model_reset();
      end else if (!reset && $urandom_range(0, 1) == 0) begin
        reset = 1'b1;
      end
      e = en;
      if ($urandom_range(0, 19) == 0) e = ~en;
      i = (!m_blk && m_cnt < MAXC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
      c = (m_cnt > 0 && m_act) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
      f = ($urandom_range(0, 39) == 0);
      cycle(e, i, c, f);
    end

    @(negedge clk);
    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_lane_gate_ctrl.md
Name: exe_lane_gate_ctrl

Overview:
- Per-lane power/activity sequencer for one memory execution pipe (RegRead -> Execute -> AgenLsu -> Writeback) under dynamic reconfiguration.
- Converts a desired lane-enable request into a safe drain-then-gate or wake-then-enable sequence.
- Drives the lane's laneActive clock-gate enable and the issue-queue select block for that lane.
- Tracks in-flight ops so the clock is never gated with a live packet in the pipe.

Parameters:
- INFLIGHT_LOG, 3: width of in-flight counter; max 2^INFLIGHT_LOG-1 live ops.
- WAKE_CYCLES, 2: cycles the clock runs before issue is unblocked (1..15).
- QUIESCE_CYCLES, 2: idle cycles after drain before the clock is gated; covers AgenLsu/writeback tail (1..15).
- RESET_ACTIVE, 1: lane state after reset (1 = ON, 0 = OFF).

Ports:
- clk  input  1  core clock, ungated.
- reset  input  1  asynchronous reset, active-low; asserted at 0.
- laneEnReq_i  input  1  desired lane state from config logic (1 = enable).
- issueValid_i  input  1  issue queue granted a packet to this lane this cycle.
- completeValid_i  input  1  ctrlPacket valid from this lane's writeback.
- flush_i  input  1  recoverFlag | exceptionFlag; kills all in-flight ops.
- laneActive_o  output  1  clock-gate enable / laneActive for the pipe.
- issueBlock_o  output  1  issue queue must not select this lane.
- cfgStable_o  output  1  lane state matches laneEnReq_i.
- inflightCnt_o  output  INFLIGHT_LOG  current live-op count.
- protErr_o  output  1  sticky protocol error.

Behaviour:
- All outputs are registered. While reset=0:
  - state = ON if RESET_ACTIVE, else OFF.
  - laneActive_o = RESET_ACTIVE; issueBlock_o = !RESET_ACTIVE.
  - inflightCnt_o = 0; protErr_o = 0; timer = 0.
  - cfgStable_o = 1 if laneEnReq_i matches the reset state (combinational, laneEnReq_i vs state).
- States: ON, DRAIN, QUIESCE, OFF, WAKE.
- ON: laneActive=1, issueBlock=0. On laneEnReq_i=0, go to DRAIN; issueBlock=1 from the next cycle. An issue in the transition cycle is still counted.
- DRAIN: laneActive=1, issueBlock=1.
  - laneEnReq_i=1: go to ON (priority).
  - Else when count=0 and issueValid_i=0: go to QUIESCE, timer=QUIESCE_CYCLES-1.
- QUIESCE: laneActive=1, issueBlock=1; timer decrements each cycle.
  - laneEnReq_i=1: go to ON (priority).
  - Timer at 0: go to OFF; laneActive=0 next cycle.
  - Nonzero count, or issue/complete activity, aborts back to DRAIN.
- OFF: laneActive=0, issueBlock=1. On laneEnReq_i=1, go to WAKE, laneActive=1, timer=WAKE_CYCLES-1.
- WAKE: laneActive=1, issueBlock=1.
  - Timer at 0: go to ON; issueBlock=0 next cycle.
  - laneEnReq_i=0 during WAKE: go straight to OFF (pipe is empty).
- Latency figures, measured from the request edge (at least two cycles on gate-off is guaranteed):
  - Gate-off from an empty pipe: laneActive falls 2+QUIESCE_CYCLES cycles after laneEnReq_i falls.
  - Unblock after wake: issueBlock falls 1+WAKE_CYCLES cycles after laneEnReq_i rises.
- In-flight counter:
  - next = cnt + issueValid_i - completeValid_i.
  - Simultaneous issue and complete leaves cnt unchanged.
  - flush_i forces cnt=0 and wins over a same-cycle issue or complete.
  - Counter saturates at both 0 and max; it never wraps.
- protErr_o sets, and stays set until reset, on any of:
  - completeValid_i with cnt=0 and no same-cycle issue (underflow);
  - issueValid_i with cnt=max and no same-cycle complete (overflow);
  - issueValid_i while issueBlock_o=1;
  - completeValid_i while laneActive_o=0.
- Reset asserted mid-sequence (any state) returns immediately to the reset state. No drain is honoured.

Decomposition:
- Shared package holds:
  - laneGateState enum typedef (ON, DRAIN, QUIESCE, OFF, WAKE);
  - default constants for WAKE_CYCLES and QUIESCE_CYCLES in the DYNAMIC_CONFIG config header.
- Sub-module lane_inflight_counter: saturating up/down counter with flush clear and underflow/overflow flags. The FSM stays in the top module.

Test Plan:
- Reset with RESET_ACTIVE=1, then laneEnReq_i=0 with cnt=0 -> issueBlock=1 at cycle 1, QUIESCE at cycle 2, laneActive=0 at cycle 4 (QUIESCE_CYCLES=2), cfgStable=1.
- Issue 3 ops, drop laneEnReq_i, complete one op every 2 cycles -> stays DRAIN until cnt=0; laneActive falls exactly QUIESCE_CYCLES+1 cycles after the last complete.
- In DRAIN with cnt=3, assert flush_i -> cnt=0 next cycle, enters QUIESCE, gates off; protErr stays 0.
- From OFF, raise laneEnReq_i -> laneActive=1 next cycle, issueBlock=0 at cycle 3 (WAKE_CYCLES=2). Drop request in WAKE -> OFF, laneActive=0.
- Toggle laneEnReq_i 1->0->1 within QUIESCE -> returns to ON, laneActive never drops.
- Drive issueValid_i while issueBlock=1, and completeValid_i at cnt=0 -> protErr=1, held through later traffic, cleared only by reset=0.
